// File: rtl/alu16.sv
// alu16: 16-bit six-control-bit ALU with one registered output stage.
// Operands are optionally zeroed, optionally inverted, then added or ANDed,
// and the result is optionally inverted. Status flags are registered with
// the result; carry and overflow describe the adder before the final inversion.
module alu16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [5:0]  c,
  input  logic        in_valid,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_c,
  output logic        flag_v
);

  // Control word fields.
  logic ex, nx, ey, ny, f, no;
  assign ex = c[5];
  assign nx = c[4];
  assign ey = c[3];
  assign ny = c[2];
  assign f  = c[1];
  assign no = c[0];

  // Zeroing happens before inversion, so ex=0/nx=1 yields all ones.
  // ex and ey are keep-enables: when one is low, its operand is forced to zero.
  logic [15:0] xb, yb;
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi = gi + 1) begin : g_operand
      assign xb[gi] = (ex & x[gi]) ^ nx;
      assign yb[gi] = (ey & y[gi]) ^ ny;
    end
  endgenerate

  logic [16:0] sum;
  logic [15:0] r;
  logic [15:0] result_next;
  logic        carry_next;
  logic        ovf_next;

  // Function select, output inversion and adder status.
  always_comb begin
    sum         = {1'b0, xb} + {1'b0, yb};
    r           = f ? sum[15:0] : (xb & yb);
    result_next = no ? ~r : r;
    carry_next  = f & sum[16];
    ovf_next    = f & (xb[15] == yb[15]) & (sum[15] != xb[15]);
  end

  // Output register: reset wins over capture; idle cycles hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= 16'h0000;
      out_valid <= 1'b0;
      flag_z    <= 1'b1;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (in_valid) begin
      out       <= result_next;
      out_valid <= 1'b1;
      flag_z    <= (result_next == 16'h0000);
      flag_n    <= result_next[15];
      flag_c    <= carry_next;
      flag_v    <= ovf_next;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu16.sv
// tb_alu16: directed vectors with hand-computed results for alu16, plus a
// sweep over the 18 named control codes against an independent reference.
module tb_alu16;

  logic        clk;
  logic        rst_n;
  logic [15:0] x;
  logic [15:0] y;
  logic [5:0]  c;
  logic        in_valid;
  logic [15:0] out;
  logic        out_valid;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_v;

  int checks = 0;
  int errors = 0;

  alu16 dut (
    .clk(clk),
    .rst_n(rst_n),
    .x(x),
    .y(y),
    .c(c),
    .in_valid(in_valid),
    .out(out),
    .out_valid(out_valid),
    .flag_z(flag_z),
    .flag_n(flag_n),
    .flag_c(flag_c),
    .flag_v(flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one operation at the falling edge; results are read 1ns after the capturing edge.
  task automatic op(input logic [15:0] xi, input logic [15:0] yi, input logic [5:0] ci);
    @(negedge clk);
    x = xi;
    y = yi;
    c = ci;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reference evaluated with integer arithmetic; flags packed as {v,c,n,z}.
  function automatic logic [19:0] ref_model(input logic [15:0] xi, input logic [15:0] yi,
                                            input logic [5:0] ci);
    int ux, uy, s, sx, sy, ss;
    logic [15:0] a, b, r, res;
    logic cy, ov;
    a = ci[5] ? xi : 16'h0000;
    b = ci[3] ? yi : 16'h0000;
    if (ci[4]) a = 16'hFFFF - a;
    if (ci[2]) b = 16'hFFFF - b;
    ux = int'(a);
    uy = int'(b);
    s  = ux + uy;
    sx = (ux >= 32768) ? ux - 65536 : ux;
    sy = (uy >= 32768) ? uy - 65536 : uy;
    ss = sx + sy;
    if (ci[1]) begin
      r  = 16'(s % 65536);
      cy = (s >= 65536);
      ov = (ss > 32767) || (ss < -32768);
    end else begin
      r  = a & b;
      cy = 1'b0;
      ov = 1'b0;
    end
    res = ci[0] ? (16'hFFFF - r) : r;
    return {ov, cy, res[15], (res == 16'h0000), res};
  endfunction

  logic [5:0] codes [18];
  logic [19:0] m;

  initial begin
    codes = '{6'd42, 6'd59, 6'd47, 6'd40, 6'd61, 6'd2, 6'd23, 6'd20, 6'd34,
              6'd10, 6'd50, 6'd14, 6'd39, 6'd27, 6'd55, 6'd31, 6'd38, 6'd26};
    rst_n = 1'b0;
    x = 16'h1234;
    y = 16'h0101;
    c = 6'd42;
    in_valid = 1'b1;

    // Reset with a valid operand presented: operand must be discarded.
    @(posedge clk);
    #1;
    check("rst_out", out, 16'h0000);
    check("rst_valid", {15'b0, out_valid}, 16'h0000);
    check("rst_flags", {12'b0, flag_v, flag_c, flag_n, flag_z}, 16'h0001);

    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    op(16'h1234, 16'h0101, 6'd42);
    check("add_out", out, 16'h1335);
    check("add_valid", {15'b0, out_valid}, 16'h0001);
    check("add_c", {15'b0, flag_c}, 16'h0000);
    check("add_z", {15'b0, flag_z}, 16'h0000);

    idle();
    check("hold_out", out, 16'h1335);
    check("hold_valid", {15'b0, out_valid}, 16'h0000);

    op(16'd5, 16'd7, 6'd59);
    check("x_minus_y", out, 16'hFFFE);
    check("x_minus_y_n", {15'b0, flag_n}, 16'h0001);
    op(16'd5, 16'd7, 6'd47);
    check("y_minus_x", out, 16'h0002);
    check("y_minus_x_n", {15'b0, flag_n}, 16'h0000);

    op(16'h00F0, 16'h0F00, 6'd61);
    check("or", out, 16'h0FF0);
    op(16'h00F0, 16'h0F00, 6'd40);
    check("and", out, 16'h0000);
    check("and_z", {15'b0, flag_z}, 16'h0001);

    op(16'hA5C3, 16'h3C5A, 6'd2);
    check("const0", out, 16'h0000);
    op(16'hA5C3, 16'h3C5A, 6'd23);
    check("const1", out, 16'h0001);
    op(16'hA5C3, 16'h3C5A, 6'd20);
    check("constm1", out, 16'hFFFF);

    op(16'hFFFF, 16'h1111, 6'd55);
    check("xinc_wrap", out, 16'h0000);
    check("xinc_wrap_z", {15'b0, flag_z}, 16'h0001);
    op(16'h0000, 16'h1111, 6'd38);
    check("xdec_wrap", out, 16'hFFFF);
    op(16'h7FFF, 16'h0001, 6'd42);
    check("ovf_out", out, 16'h8000);
    check("ovf_flags", {12'b0, flag_v, flag_c, flag_n, flag_z}, 16'h000A);

    // Reset mid-stream with a valid operand present.
    @(negedge clk);
    rst_n = 1'b0;
    x = 16'h4321;
    y = 16'h1111;
    c = 6'd42;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out", out, 16'h0000);
    check("midrst_valid", {15'b0, out_valid}, 16'h0000);
    check("midrst_z", {15'b0, flag_z}, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back sweep: in_valid is never dropped, so out_valid must stay high.
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 18; k++) begin
        op(16'(i * 255), 16'(i * 567), codes[k]);
        m = ref_model(16'(i * 255), 16'(i * 567), codes[k]);
        check($sformatf("sweep_out i=%0d c=%0d", i, codes[k]), out, m[15:0]);
        check($sformatf("sweep_flags i=%0d c=%0d", i, codes[k]),
              {12'b0, flag_v, flag_c, flag_n, flag_z}, {12'b0, m[19:16]});
        check($sformatf("sweep_valid i=%0d c=%0d", i, codes[k]),
              {15'b0, out_valid}, 16'h0001);
      end
    end

    idle();
    check("end_valid", {15'b0, out_valid}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
